// File: rtl/ascii_hex_pkg.sv
// Shared definitions for the ASCII hex parser: FSM states, delimiter
// codes, digit-counter width and a delimiter classification helper.
package ascii_hex_pkg;

  // Wide enough to hold a count of 16 digits without wrapping.
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_ONE = 5'd1;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2C;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no digits held
    ST_ACC  = 2'd1,  // partial word being accumulated
    ST_OUT  = 2'd2,  // completed word offered downstream
    ST_SKIP = 2'd3   // discarding characters after an illegal one
  } state_t;

  function automatic logic is_delim_f(input logic [7:0] c);
    return (c == CH_CR) || (c == CH_LF) || (c == CH_SP) || (c == CH_COMMA);
  endfunction

endpackage

// File: rtl/ascii_hex_char.sv
// Combinational classifier for one ASCII byte: hex digit (with its nibble
// value), word delimiter, or neither. Lower-case digits are optional.
module ascii_hex_char
  import ascii_hex_pkg::*;
#(
  parameter int LOWER_EN = 1
) (
  input  logic [7:0] char_in,
  output logic       is_digit,
  output logic       is_delim,
  output logic [3:0] nibble
);

  // Decode the byte; letters map via their low nibble plus nine.
  always_comb begin
    is_digit = 1'b0;
    nibble   = 4'd0;
    is_delim = is_delim_f(char_in);
    if ((char_in >= 8'h30) && (char_in <= 8'h39)) begin
      is_digit = 1'b1;
      nibble   = char_in[3:0];
    end else if ((char_in >= 8'h41) && (char_in <= 8'h46)) begin
      is_digit = 1'b1;
      nibble   = char_in[3:0] + 4'd9;
    end else if ((LOWER_EN != 0) && (char_in >= 8'h61) && (char_in <= 8'h66)) begin
      is_digit = 1'b1;
      nibble   = char_in[3:0] + 4'd9;
    end else begin
      is_digit = 1'b0;
      nibble   = 4'd0;
    end
  end

endmodule

// File: rtl/ascii_hex_parser.sv
// Streaming ASCII hex parser: accumulates up to CHAR_NUM hex digits into a
// word, emits early on a delimiter, flags illegal characters and skips to
// the next delimiter after one. Handshakes on both sides; all outputs are
// registered.
module ascii_hex_parser
  import ascii_hex_pkg::*;
#(
  parameter int CHAR_NUM = 2,
  parameter int LOWER_EN = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  iVALID,
  input  logic [7:0]            iCHAR,
  output logic                  oREADY,
  output logic                  oVALID,
  output logic [CHAR_NUM*4-1:0] oDATA,
  output logic [4:0]            oCNT,
  input  logic                  iREADY,
  output logic                  oERR
);

  localparam int W = CHAR_NUM * 4;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAR_NUM);

  state_t           state_r, state_nxt;
  logic [W-1:0]     acc_r, acc_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic [W-1:0]     data_r, data_nxt;
  logic [CNT_W-1:0] ocnt_r, ocnt_nxt;
  logic             valid_r, valid_nxt;
  logic             ready_r, ready_nxt;
  logic             err_r, err_nxt;

  logic             is_digit;
  logic             is_delim;
  logic [3:0]       nibble;
  logic             char_acc;
  logic [W-1:0]     nib_ext;
  logic [W-1:0]     acc_shift;
  logic [CNT_W-1:0] cnt_inc;

  ascii_hex_char #(.LOWER_EN(LOWER_EN)) u_char (
    .char_in  (iCHAR),
    .is_digit (is_digit),
    .is_delim (is_delim),
    .nibble   (nibble)
  );

  // Shift helpers; written without a slice so CHAR_NUM=1 stays legal.
  always_comb begin
    nib_ext       = '0;
    nib_ext[3:0]  = nibble;
    acc_shift     = (acc_r << 4) | nib_ext;
    cnt_inc       = cnt_r + CNT_ONE;
    char_acc      = iVALID && ready_r;
  end

  // Next-state and next-output logic for the parser FSM.
  always_comb begin
    state_nxt = state_r;
    acc_nxt   = acc_r;
    cnt_nxt   = cnt_r;
    data_nxt  = data_r;
    ocnt_nxt  = ocnt_r;
    err_nxt   = 1'b0;
    case (state_r)
      ST_IDLE, ST_ACC: begin
        if (char_acc) begin
          if (is_digit) begin
            if (cnt_inc == CNT_FULL) begin
              data_nxt  = acc_shift;
              ocnt_nxt  = CNT_FULL;
              acc_nxt   = '0;
              cnt_nxt   = '0;
              state_nxt = ST_OUT;
            end else begin
              acc_nxt   = acc_shift;
              cnt_nxt   = cnt_inc;
              state_nxt = ST_ACC;
            end
          end else if (is_delim) begin
            // A delimiter only closes a word that has digits in it.
            if (state_r == ST_ACC) begin
              data_nxt  = acc_r;
              ocnt_nxt  = cnt_r;
              acc_nxt   = '0;
              cnt_nxt   = '0;
              state_nxt = ST_OUT;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            err_nxt   = 1'b1;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = ST_SKIP;
          end
        end else begin
          state_nxt = state_r;
        end
      end
      ST_OUT: begin
        if (iREADY) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_OUT;
        end
      end
      ST_SKIP: begin
        if (char_acc && is_delim) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_SKIP;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        acc_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
    valid_nxt = (state_nxt == ST_OUT);
    ready_nxt = (state_nxt != ST_OUT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
      acc_r   <= '0;
      cnt_r   <= '0;
      data_r  <= '0;
      ocnt_r  <= '0;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt;
      acc_r   <= acc_nxt;
      cnt_r   <= cnt_nxt;
      data_r  <= data_nxt;
      ocnt_r  <= ocnt_nxt;
      valid_r <= valid_nxt;
      ready_r <= ready_nxt;
      err_r   <= err_nxt;
    end
  end

  assign oREADY = ready_r;
  assign oVALID = valid_r;
  assign oDATA  = data_r;
  assign oCNT   = ocnt_r;
  assign oERR   = err_r;

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Bench for ascii_hex_parser: three instances (2 digits, 4 digits, 4 digits
// upper-case only), directed scenarios plus random character streams
// checked against a string-level reference model.
module tb_ascii_hex_parser;

  logic             CLK = 1'b0;
  logic             rst_n;
  logic [2:0]       vin;
  logic [2:0][7:0]  ch;
  logic [2:0]       ird;
  logic [2:0]       ordy, oval, oerr;
  logic [2:0][4:0]  ocnt;
  logic [7:0]       od0;
  logic [15:0]      od1, od2;
  logic [2:0][63:0] odx;
  logic [2:0]       rr;

  int checks = 0;
  int errors = 0;

  logic [7:0]  cq[$];
  logic [68:0] ew[$];
  logic [68:0] gw[$];
  int          eerr;
  int          errc;

  always #5 CLK = ~CLK;

  ascii_hex_parser #(.CHAR_NUM(2), .LOWER_EN(1)) u0 (
    .CLK(CLK), .RST_N(rst_n), .iVALID(vin[0]), .iCHAR(ch[0]), .oREADY(ordy[0]),
    .oVALID(oval[0]), .oDATA(od0), .oCNT(ocnt[0]), .iREADY(ird[0]), .oERR(oerr[0]));
  ascii_hex_parser #(.CHAR_NUM(4), .LOWER_EN(1)) u1 (
    .CLK(CLK), .RST_N(rst_n), .iVALID(vin[1]), .iCHAR(ch[1]), .oREADY(ordy[1]),
    .oVALID(oval[1]), .oDATA(od1), .oCNT(ocnt[1]), .iREADY(ird[1]), .oERR(oerr[1]));
  ascii_hex_parser #(.CHAR_NUM(4), .LOWER_EN(0)) u2 (
    .CLK(CLK), .RST_N(rst_n), .iVALID(vin[2]), .iCHAR(ch[2]), .oREADY(ordy[2]),
    .oVALID(oval[2]), .oDATA(od2), .oCNT(ocnt[2]), .iREADY(ird[2]), .oERR(oerr[2]));

  assign odx[0] = {56'd0, od0};
  assign odx[1] = {48'd0, od1};
  assign odx[2] = {48'd0, od2};

  // Collect transferred words and error pulses away from the active edge.
  always @(negedge CLK) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (oval[k] && ird[k]) gw.push_back({ocnt[k], odx[k]});
        if (oerr[k]) errc++;
      end
    end
  end

  // Optional random downstream backpressure.
  always @(posedge CLK) begin
    #1;
    for (int k = 0; k < 3; k++) begin
      if (rr[k]) ird[k] = 1'($urandom_range(0, 1));
    end
  end

  function automatic int digits_of(int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic int hexval(logic [7:0] c, bit lower);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (lower && c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  // Reference: walk the character string and list the words it should yield.
  task automatic model(int k);
    int n, len, d;
    bit skip, delim;
    logic [63:0] v;
    n = digits_of(k);
    ew.delete(); eerr = 0; len = 0; v = 64'd0; skip = 1'b0;
    foreach (cq[i]) begin
      d = hexval(cq[i], k != 2);
      delim = (cq[i] == 8'h0D) || (cq[i] == 8'h0A) || (cq[i] == 8'h20) || (cq[i] == 8'h2C);
      if (skip) begin
        if (delim) skip = 1'b0;
      end else if (d >= 0) begin
        v = v * 64'd16 + 64'(d);
        len++;
        if (len == n) begin ew.push_back({5'(len), v}); v = 64'd0; len = 0; end
      end else if (delim) begin
        if (len > 0) ew.push_back({5'(len), v});
        v = 64'd0; len = 0;
      end else begin
        eerr++; v = 64'd0; len = 0; skip = 1'b1;
      end
    end
  endtask

  task automatic chk(string tag, logic [68:0] obs, logic [68:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Present one character and hold it until the DUT accepts it.
  task automatic send(int k, logic [7:0] c);
    int  n;
    bit  done;
    n = 0; done = 1'b0;
    vin[k] = 1'b1; ch[k] = c;
    while (!done) begin
      @(negedge CLK);
      if (ordy[k]) done = 1'b1;
      else begin
        n++;
        if (n > 60) begin
          checks++; errors++;
          $error("FAIL send_timeout inst=%0d observed=stalled expected=accept", k);
          done = 1'b1;
        end
      end
      tick();
    end
    vin[k] = 1'b0;
  endtask

  task automatic send_q(int k);
    foreach (cq[i]) send(k, cq[i]);
  endtask

  task automatic start(int k, string s);
    cq.delete();
    for (int i = 0; i < s.len(); i++) cq.push_back(s[i]);
    model(k);
    gw.delete(); errc = 0;
  endtask

  task automatic finish_case(int k, string tag);
    rr[k] = 1'b0; ird[k] = 1'b1;
    repeat (8) tick();
    chk($sformatf("%s_nwords", tag), 69'(gw.size()), 69'(ew.size()));
    for (int i = 0; i < ew.size(); i++) begin
      if (i < gw.size()) chk($sformatf("%s_word%0d", tag, i), gw[i], ew[i]);
    end
    chk($sformatf("%s_nerr", tag), 69'(errc), 69'(eerr));
  endtask

  task automatic check_idle_outputs(string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_ready%0d", tag, k), 69'(ordy[k]), 69'd1);
      chk($sformatf("%s_valid%0d", tag, k), 69'(oval[k]), 69'd0);
      chk($sformatf("%s_err%0d", tag, k), 69'(oerr[k]), 69'd0);
      chk($sformatf("%s_data%0d", tag, k), {ocnt[k], odx[k]}, 69'd0);
    end
  endtask

  string dig_tab = "0123456789ABCDEFabcdef";
  string del_tab = "\r\n ,";
  string bad_tab = "GgZ!.x:/";

  initial begin
    int r;
    rst_n = 1'b0; vin = 3'b000; ch = '0; ird = 3'b111; rr = 3'b000;
    repeat (3) tick();
    @(negedge CLK);
    check_idle_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // "3F": word appears one cycle after 'F', then held under backpressure.
    start(0, "3F");
    ird[0] = 1'b0;
    send(0, "3");
    @(negedge CLK);
    chk("lat_before", 69'(oval[0]), 69'd0);
    tick();
    send(0, "F");
    @(negedge CLK);
    chk("lat_valid", 69'(oval[0]), 69'd1);
    chk("lat_word", {ocnt[0], odx[0]}, {5'd2, 64'h3F});
    chk("lat_ready", 69'(ordy[0]), 69'd0);
    tick();
    finish_case(0, "w3F");

    // "C4" held for ten cycles, then more characters once released.
    start(0, "C4\r37,");
    ird[0] = 1'b0;
    send(0, "C"); send(0, "4");
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk($sformatf("hold_ready%0d", i), 69'(ordy[0]), 69'd0);
      chk($sformatf("hold_data%0d", i), 69'(od0), 69'h0C4);
      tick();
    end
    ird[0] = 1'b1;
    send(0, 8'h0D); send(0, "3"); send(0, "7"); send(0, ",");
    finish_case(0, "hold");

    // "a5" CR on the 4-digit instances, with and without lower case.
    start(1, "a5\r");
    send_q(1);
    finish_case(1, "lower_on");
    start(2, "a5\r");
    send(2, "a");
    @(negedge CLK);
    chk("err_pulse", 69'(oerr[2]), 69'd1);
    tick();
    @(negedge CLK);
    chk("err_single", 69'(oerr[2]), 69'd0);
    tick();
    send(2, "5"); send(2, 8'h0D);
    finish_case(2, "lower_off");

    // Illegal character mid-word, skip to LF, then a clean word.
    start(0, "1G2\n7E");
    send_q(0);
    finish_case(0, "skip");

    // Reset after one digit discards it.
    start(0, "5B");
    send(0, "9");
    rst_n = 1'b0;
    tick();
    @(negedge CLK);
    check_idle_outputs("midreset");
    tick();
    rst_n = 1'b1;
    send_q(0);
    finish_case(0, "after_rst");

    // Back-to-back words with a terminator between them.
    start(0, "FF\r00");
    send_q(0);
    finish_case(0, "b2b");

    // Random streams with random downstream readiness.
    for (int k = 0; k < 3; k++) begin
      cq.delete();
      for (int i = 0; i < 150; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 70) cq.push_back(dig_tab[int'($urandom_range(0, 21))]);
        else if (r < 88) cq.push_back(del_tab[int'($urandom_range(0, 3))]);
        else cq.push_back(bad_tab[int'($urandom_range(0, 7))]);
      end
      cq.push_back(8'h0D);
      model(k);
      gw.delete(); errc = 0;
      rr[k] = 1'b1;
      send_q(k);
      finish_case(k, $sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
